// File: rtl/vga_rect_sched.sv
// Two-requester rectangle scheduler: round-robin arbitration of draw requests,
// commit of the winner on the blanking line, and a registered pixel painter.
package vga_rect_sched_pkg;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] color;
  } rect_t;

  localparam int unsigned RECT_W = $bits(rect_t);
endpackage

module vga_rect_sched
  import vga_rect_sched_pkg::*;
#(
  parameter int unsigned VBL_LINE = 480
) (
  input  logic               CLK_50,
  input  logic               RESET,
  input  logic [COORD_W-1:0] CounterX,
  input  logic [COORD_W-1:0] CounterY,
  input  logic               InDisplayArea,
  input  logic               req0,
  input  logic               req1,
  input  logic [RECT_W-1:0]  rect0,
  input  logic [RECT_W-1:0]  rect1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [2:0]         RED,
  output logic [2:0]         GREEN,
  output logic [1:0]         BLUE,
  output logic               busy,
  output logic               commit
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VBL = 2'd1,
    COMMIT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               prio1_q, prio1_d;  // set when requester 1 wins a tie
  rect_t              pending_q, pending_d;
  rect_t              active_q, active_d;
  logic               active_valid_q, active_valid_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               busy_q, busy_d;
  logic               commit_q, commit_d;
  logic [COLOR_W-1:0] rgb_q, rgb_d;
  logic               win1;
  logic               at_vbl;
  logic               hit;

  assign win1   = req1 && (!req0 || prio1_q);
  assign at_vbl = (CounterX == '0) && (CounterY == COORD_W'(VBL_LINE));

  // Scheduler FSM: grant in IDLE, hold until the blanking line, then commit.
  always_comb begin
    state_d        = state_q;
    prio1_d        = prio1_q;
    pending_d      = pending_q;
    active_d       = active_q;
    active_valid_d = active_valid_q;
    gnt0_d         = 1'b0;
    gnt1_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0_d    = !win1;
          gnt1_d    = win1;
          pending_d = win1 ? rect_t'(rect1) : rect_t'(rect0);
          prio1_d   = !win1;
          state_d   = WAIT_VBL;
        end
      end
      WAIT_VBL: begin
        if (at_vbl) begin
          active_d       = pending_q;
          active_valid_d = 1'b1;
          state_d        = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    commit_d = (state_d == COMMIT);
  end

  // Inverted rectangles fail one of the inclusive bounds and so paint nothing.
  always_comb begin
    hit = InDisplayArea && active_valid_q
       && (CounterX >= active_q.x0) && (CounterX <= active_q.x1)
       && (CounterY >= active_q.y0) && (CounterY <= active_q.y1);
    rgb_d = hit ? active_q.color : '0;
  end

  always_ff @(posedge CLK_50 or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      prio1_q        <= 1'b0;
      pending_q      <= '0;
      active_q       <= '0;
      active_valid_q <= 1'b0;
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      busy_q         <= 1'b0;
      commit_q       <= 1'b0;
      rgb_q          <= '0;
    end else begin
      state_q        <= state_d;
      prio1_q        <= prio1_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
      active_valid_q <= active_valid_d;
      gnt0_q         <= gnt0_d;
      gnt1_q         <= gnt1_d;
      busy_q         <= busy_d;
      commit_q       <= commit_d;
      rgb_q          <= rgb_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign busy   = busy_q;
  assign commit = commit_q;
  assign RED    = rgb_q[7:5];
  assign GREEN  = rgb_q[4:2];
  assign BLUE   = rgb_q[1:0];

endmodule
